// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_arbiter
// Purpose  : Shares one memory port between instruction fetch and load/store.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_arbiter #(
  parameter int WORD_SIZE     = 16,
  parameter int DATA_PRIORITY = 1,
  parameter int TIMEOUT       = 255,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_req,
  input  logic [WORD_SIZE-1:0] fetch_addr,
  output logic                 fetch_done,
  output logic [WORD_SIZE-1:0] fetch_data,
  input  logic                 data_req_read,
  input  logic                 data_req_write,
  input  logic [WORD_SIZE-1:0] data_addr,
  input  logic [WORD_SIZE-1:0] data_wdata,
  output logic                 data_done,
  output logic [WORD_SIZE-1:0] data_rdata,
  output logic                 sig_fetch,
  output logic                 sig_read,
  output logic                 sig_write,
  output logic [WORD_SIZE-1:0] address_fetch_out,
  output logic [WORD_SIZE-1:0] address_data_out,
  output logic [WORD_SIZE-1:0] data_write_out,
  input  logic [WORD_SIZE-1:0] mem_data_in,
  input  logic                 input_ready,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DREAD  = 2'd2,
    S_DWRITE = 2'd3
  } state_t;

  localparam logic             c_prio   = (DATA_PRIORITY != 0);
  localparam logic             c_tmo_en = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] c_tmo    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

  state_t               r_state;
  state_t               w_next;
  logic                 r_last_data;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_sig_fetch, r_sig_read, r_sig_write;
  logic                 r_fetch_done, r_data_done;
  logic                 r_timeout_err;
  logic [WORD_SIZE-1:0] r_fetch_data, r_data_rdata;
  logic [WORD_SIZE-1:0] r_addr_fetch, r_addr_data, r_wdata;

  logic w_data_req, w_turn, w_grant_data, w_access, w_tmo_hit, w_start, w_end;

  assign w_data_req   = data_req_read | data_req_write;
  assign w_turn       = r_fetch_done | r_data_done;
  // With both pending and no data priority, grant whoever did not win last.
  assign w_grant_data = w_data_req & (~fetch_req | c_prio | ~r_last_data);
  assign w_access     = (r_state != S_IDLE);
  assign w_tmo_hit    = c_tmo_en & (r_cnt == c_tmo);
  assign w_start      = ~w_access & (w_next != S_IDLE);
  assign w_end        = w_access & (w_next == S_IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_turn) begin
          if (w_grant_data)   w_next = data_req_read ? S_DREAD : S_DWRITE;
          else if (fetch_req) w_next = S_FETCH;
        end
      end
      default: begin
        if (input_ready || w_tmo_hit) w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_last_data   <= 1'b0;
      r_cnt         <= '0;
      r_sig_fetch   <= 1'b0;
      r_sig_read    <= 1'b0;
      r_sig_write   <= 1'b0;
      r_fetch_done  <= 1'b0;
      r_data_done   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_fetch_data  <= '0;
      r_data_rdata  <= '0;
      r_addr_fetch  <= '0;
      r_addr_data   <= '0;
      r_wdata       <= '0;
    end else begin
      r_state      <= w_next;
      r_sig_fetch  <= (w_next == S_FETCH);
      r_sig_read   <= (w_next == S_DREAD);
      r_sig_write  <= (w_next == S_DWRITE);
      r_fetch_done <= w_end & (r_state == S_FETCH);
      r_data_done  <= w_end & (r_state != S_FETCH);

      if (w_start) begin
        r_cnt <= '0;
        if (w_next == S_FETCH) begin
          r_addr_fetch <= fetch_addr;
          r_last_data  <= 1'b0;
        end else begin
          r_addr_data <= data_addr;
          r_last_data <= 1'b1;
          if (w_next == S_DWRITE) r_wdata <= data_wdata;
        end
      end else if (w_access && !input_ready && !w_tmo_hit && (r_cnt != '1)) begin
        r_cnt <= r_cnt + c_one;
      end

      if (w_access && input_ready) begin
        if (r_state == S_FETCH) r_fetch_data <= mem_data_in;
        if (r_state == S_DREAD) r_data_rdata <= mem_data_in;
      end

      // A late input_ready in the timeout cycle still counts as a normal completion.
      if (w_access && !input_ready && w_tmo_hit) r_timeout_err <= 1'b1;
    end
  end

  assign sig_fetch         = r_sig_fetch;
  assign sig_read          = r_sig_read;
  assign sig_write         = r_sig_write;
  assign fetch_done        = r_fetch_done;
  assign data_done         = r_data_done;
  assign fetch_data        = r_fetch_data;
  assign data_rdata        = r_data_rdata;
  assign address_fetch_out = r_addr_fetch;
  assign address_data_out  = r_addr_data;
  assign data_write_out    = r_wdata;
  assign busy              = w_access;
  assign timeout_err       = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_arbiter
// Purpose  : Self-checking bench; instance 0 data priority, instance 1 round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_arbiter;

  localparam int T  = 4;
  localparam int KF = 1;
  localparam int KR = 2;
  localparam int KW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, fetch_req, data_req_read, data_req_write, input_ready;
  logic [1:0][15:0] fetch_addr, data_addr, data_wdata, mem_data_in;
  logic [1:0]       fetch_done, data_done, sig_fetch, sig_read, sig_write, busy, timeout_err;
  logic [1:0][15:0] fetch_data, data_rdata, address_fetch_out, address_data_out, data_write_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what each instance should currently be presenting.
  bit          last_data[2];
  logic [15:0] e_afetch[2], e_adata[2], e_wout[2], e_fd[2], e_dr[2];
  logic        e_te[2];

  mem_access_arbiter #(.WORD_SIZE(16), .DATA_PRIORITY(1), .TIMEOUT(T), .CNT_W(8)) u_dut0 (
    .clk(clk), .reset(rst[0]),
    .fetch_req(fetch_req[0]), .fetch_addr(fetch_addr[0]),
    .fetch_done(fetch_done[0]), .fetch_data(fetch_data[0]),
    .data_req_read(data_req_read[0]), .data_req_write(data_req_write[0]),
    .data_addr(data_addr[0]), .data_wdata(data_wdata[0]),
    .data_done(data_done[0]), .data_rdata(data_rdata[0]),
    .sig_fetch(sig_fetch[0]), .sig_read(sig_read[0]), .sig_write(sig_write[0]),
    .address_fetch_out(address_fetch_out[0]), .address_data_out(address_data_out[0]),
    .data_write_out(data_write_out[0]), .mem_data_in(mem_data_in[0]),
    .input_ready(input_ready[0]), .busy(busy[0]), .timeout_err(timeout_err[0])
  );

  mem_access_arbiter #(.WORD_SIZE(16), .DATA_PRIORITY(0), .TIMEOUT(T), .CNT_W(8)) u_dut1 (
    .clk(clk), .reset(rst[1]),
    .fetch_req(fetch_req[1]), .fetch_addr(fetch_addr[1]),
    .fetch_done(fetch_done[1]), .fetch_data(fetch_data[1]),
    .data_req_read(data_req_read[1]), .data_req_write(data_req_write[1]),
    .data_addr(data_addr[1]), .data_wdata(data_wdata[1]),
    .data_done(data_done[1]), .data_rdata(data_rdata[1]),
    .sig_fetch(sig_fetch[1]), .sig_read(sig_read[1]), .sig_write(sig_write[1]),
    .address_fetch_out(address_fetch_out[1]), .address_data_out(address_data_out[1]),
    .data_write_out(data_write_out[1]), .mem_data_in(mem_data_in[1]),
    .input_ready(input_ready[1]), .busy(busy[1]), .timeout_err(timeout_err[1])
  );

  function automatic void model_reset(input int d);
    last_data[d] = 1'b0;
    e_afetch[d]  = '0;
    e_adata[d]   = '0;
    e_wout[d]    = '0;
    e_fd[d]      = '0;
    e_dr[d]      = '0;
    e_te[d]      = 1'b0;
  endfunction

  // Arbitration rule: lone requester wins; both pending -> data on instance 0,
  // otherwise the side that did not win last time.
  function automatic int pick(input int d, input bit fp, input bit dp, input bit rd);
    int dk;
    dk = rd ? KR : KW;
    if (!dp) return KF;
    if (!fp) return dk;
    if (d == 0) return dk;
    return last_data[d] ? KF : dk;
  endfunction

  // Runs one granted access from the sampling edge through the done cycle.
  // k = strobe cycle in which input_ready is raised (beyond T+1 means never).
  task automatic drive_access(input int d, input int kind, input logic [15:0] addr,
                              input logic [15:0] wdata, input int k,
                              input logic [15:0] rd, input bit scramble);
    int       n;
    bit       to;
    logic [5:0] exp_ctl, got_ctl;
    to = (k > T + 1);
    n  = to ? T + 1 : k;
    if (kind == KF) begin
      e_afetch[d]  = addr;
      last_data[d] = 1'b0;
    end else begin
      e_adata[d]   = addr;
      last_data[d] = 1'b1;
      if (kind == KW) e_wout[d] = wdata;
    end
    exp_ctl = {(kind == KF), (kind == KR), (kind == KW), 3'b100};
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      got_ctl = {sig_fetch[d], sig_read[d], sig_write[d], busy[d], fetch_done[d], data_done[d]};
      n_checks++;
      if (got_ctl !== exp_ctl) begin
        n_fail++;
        $display("FAIL access_ctl dut%0d cyc%0d: got %b expected %b", d, j, got_ctl, exp_ctl);
      end
      n_checks++;
      if ({address_fetch_out[d], address_data_out[d], data_write_out[d]} !==
          {e_afetch[d], e_adata[d], e_wout[d]}) begin
        n_fail++;
        $display("FAIL latched dut%0d cyc%0d: got %h/%h/%h expected %h/%h/%h", d, j,
                 address_fetch_out[d], address_data_out[d], data_write_out[d],
                 e_afetch[d], e_adata[d], e_wout[d]);
      end
      if (scramble && j == 1) begin
        if (kind == KF) fetch_addr[d] = ~addr;
        else begin
          data_addr[d]  = ~addr;
          data_wdata[d] = 16'hFFFF;
        end
      end
      input_ready[d] = (j == k);
      mem_data_in[d] = (j == k) ? rd : 16'($urandom);
    end
    @(negedge clk);
    input_ready[d] = 1'b0;
    if (to) e_te[d] = 1'b1;
    else if (kind == KF) e_fd[d] = rd;
    else if (kind == KR) e_dr[d] = rd;
    exp_ctl = {3'b000, 1'b0, (kind == KF), (kind != KF)};
    got_ctl = {sig_fetch[d], sig_read[d], sig_write[d], busy[d], fetch_done[d], data_done[d]};
    n_checks++;
    if (got_ctl !== exp_ctl) begin
      n_fail++;
      $display("FAIL done_ctl dut%0d: got %b expected %b", d, got_ctl, exp_ctl);
    end
    n_checks++;
    if ({fetch_data[d], data_rdata[d], timeout_err[d]} !== {e_fd[d], e_dr[d], e_te[d]}) begin
      n_fail++;
      $display("FAIL done_data dut%0d: got %h/%h/%b expected %h/%h/%b", d,
               fetch_data[d], data_rdata[d], timeout_err[d], e_fd[d], e_dr[d], e_te[d]);
    end
  endtask

  // Cycle after done (or any quiet cycle): nothing may be granted or strobed.
  task automatic idle_cycle(input int d);
    logic [5:0] got_ctl;
    @(negedge clk);
    got_ctl = {sig_fetch[d], sig_read[d], sig_write[d], busy[d], fetch_done[d], data_done[d]};
    n_checks++;
    if (got_ctl !== 6'b0) begin
      n_fail++;
      $display("FAIL idle_ctl dut%0d: got %b expected 000000", d, got_ctl);
    end
    n_checks++;
    if ({fetch_data[d], data_rdata[d], timeout_err[d]} !== {e_fd[d], e_dr[d], e_te[d]}) begin
      n_fail++;
      $display("FAIL idle_data dut%0d: got %h/%h/%b expected %h/%h/%b", d,
               fetch_data[d], data_rdata[d], timeout_err[d], e_fd[d], e_dr[d], e_te[d]);
    end
  endtask

  task automatic test_reset();
    rst = 2'b11;
    fetch_req = '0; data_req_read = '0; data_req_write = '0; input_ready = '0;
    fetch_addr = '0; data_addr = '0; data_wdata = '0; mem_data_in = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      n_checks++;
      if ({sig_fetch[d], sig_read[d], sig_write[d], busy[d], fetch_done[d], data_done[d],
           timeout_err[d]} !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_ctl dut%0d: got %b%b%b%b%b%b%b expected 0000000", d, sig_fetch[d],
                 sig_read[d], sig_write[d], busy[d], fetch_done[d], data_done[d], timeout_err[d]);
      end
      n_checks++;
      if ({fetch_data[d], data_rdata[d], address_fetch_out[d], address_data_out[d],
           data_write_out[d]} !== {e_fd[d], e_dr[d], e_afetch[d], e_adata[d], e_wout[d]}) begin
        n_fail++;
        $display("FAIL reset_data dut%0d: got %h %h %h %h %h expected zeros", d, fetch_data[d],
                 data_rdata[d], address_fetch_out[d], address_data_out[d], data_write_out[d]);
      end
    end
    rst = 2'b00;
  endtask

  task automatic test_fetch();
    fetch_req[0] = 1'b1; fetch_addr[0] = 16'h0010;
    drive_access(0, KF, 16'h0010, 16'h0000, 3, 16'hA5A5, 1'b0);
    fetch_req[0] = 1'b0;
    idle_cycle(0);
  endtask

  task automatic test_priority();
    fetch_req[0] = 1'b1; fetch_addr[0] = 16'h0040;
    data_req_read[0] = 1'b1; data_addr[0] = 16'h0020;
    drive_access(0, KR, 16'h0020, 16'h0000, 2, 16'h5A5A, 1'b0);
    data_req_read[0] = 1'b0;
    idle_cycle(0);
    drive_access(0, KF, 16'h0040, 16'h0000, 1, 16'h1111, 1'b0);
    fetch_req[0] = 1'b0;
    idle_cycle(0);
  endtask

  task automatic test_round_robin();
    int order[4] = '{KR, KF, KR, KF};
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    model_reset(1);
    fetch_req[1] = 1'b1; fetch_addr[1] = 16'h0100;
    data_req_read[1] = 1'b1; data_addr[1] = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      drive_access(1, order[i], (order[i] == KF) ? 16'h0100 : 16'h0200, 16'h0000, 1,
                   16'h0300 + 16'(i), 1'b0);
      idle_cycle(1);
    end
    fetch_req[1] = 1'b0; data_req_read[1] = 1'b0;
    idle_cycle(1);
  endtask

  task automatic test_store();
    data_req_write[0] = 1'b1; data_addr[0] = 16'h0030; data_wdata[0] = 16'h1234;
    drive_access(0, KW, 16'h0030, 16'h1234, 3, 16'hDEAD, 1'b1);
    data_req_write[0] = 1'b0;
    idle_cycle(0);
  endtask

  task automatic test_coincide();
    fetch_req[1] = 1'b1; fetch_addr[1] = 16'h0400;
    drive_access(1, KF, 16'h0400, 16'h0000, T + 1, 16'hC0DE, 1'b0);
    fetch_req[1] = 1'b0;
    idle_cycle(1);
  endtask

  task automatic test_timeout();
    fetch_req[0] = 1'b1; fetch_addr[0] = 16'h0050;
    drive_access(0, KF, 16'h0050, 16'h0000, 100, 16'hBAD0, 1'b0);
    fetch_req[0] = 1'b0;
    idle_cycle(0);
    fetch_req[0] = 1'b1; fetch_addr[0] = 16'h0052;
    drive_access(0, KF, 16'h0052, 16'h0000, 2, 16'h7777, 1'b0);
    fetch_req[0] = 1'b0;
    idle_cycle(0);
  endtask

  task automatic test_idle_ready();
    input_ready[0] = 1'b1; mem_data_in[0] = 16'hBEEF;
    repeat (3) idle_cycle(0);
    input_ready[0] = 1'b0;
  endtask

  task automatic test_random(input int d);
    bit          fp, dp;
    int          kind, r;
    logic [15:0] a;
    fp = 1'b0; dp = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (!fp && $urandom_range(0, 1) == 1) begin
        fetch_req[d] = 1'b1; fetch_addr[d] = 16'($urandom); fp = 1'b1;
      end
      if (!dp && (!fp || $urandom_range(0, 1) == 1)) begin
        r = $urandom_range(0, 2);
        data_req_read[d]  = (r != 1);
        data_req_write[d] = (r != 0);
        data_addr[d]  = 16'($urandom);
        data_wdata[d] = 16'($urandom);
        dp = 1'b1;
      end
      kind = pick(d, fp, dp, data_req_read[d]);
      a    = (kind == KF) ? fetch_addr[d] : data_addr[d];
      drive_access(d, kind, a, data_wdata[d], $urandom_range(1, 7), 16'($urandom), 1'b1);
      if (kind == KF) begin
        fetch_req[d] = 1'b0; fp = 1'b0;
      end else begin
        data_req_read[d] = 1'b0; data_req_write[d] = 1'b0; dp = 1'b0;
      end
      idle_cycle(d);
    end
    fetch_req[d] = 1'b0; data_req_read[d] = 1'b0; data_req_write[d] = 1'b0;
    idle_cycle(d);
  endtask

  task automatic test_reset_mid();
    data_req_read[0] = 1'b1; data_addr[0] = 16'h0060;
    @(negedge clk);
    n_checks++;
    if ({sig_read[0], busy[0]} !== 2'b11) begin
      n_fail++;
      $display("FAIL midrst_pre: got sig_read=%b busy=%b expected 1 1", sig_read[0], busy[0]);
    end
    rst[0] = 1'b1;
    data_req_read[0] = 1'b0;
    @(negedge clk);
    model_reset(0);
    n_checks++;
    if ({sig_read[0], busy[0], data_done[0], timeout_err[0]} !== 4'b0) begin
      n_fail++;
      $display("FAIL midrst_ctl: got %b%b%b%b expected 0000", sig_read[0], busy[0],
               data_done[0], timeout_err[0]);
    end
    rst[0] = 1'b0;
    idle_cycle(0);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_round_robin();
    test_store();
    test_coincide();
    test_timeout();
    test_idle_ready();
    test_random(0);
    test_random(1);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Sequences the shared single-port memory interface between the instruction-fetch requester and the load/store requester.
- Accepts requests, arbitrates, and drives the memory I/O block's request strobes (sig_fetch / sig_read / sig_write), fetch and data addresses, and write data.
- Waits for the memory's input_ready completion, captures read data, and returns a one-cycle done pulse to the winning requester.
- Sits between the CPU control/datapath and the memory I/O block.

Parameters:
WORD_SIZE, 16, width of addresses and data words
DATA_PRIORITY, 1, 1 = data requests always win over fetch; 0 = round-robin when both pending
TIMEOUT, 255, max cycles waiting for input_ready before abort; 0 disables timeout
CNT_W, 8, width of the wait counter (must hold TIMEOUT)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
fetch_req  input  1  fetch requester wants an instruction word
fetch_addr  input  WORD_SIZE  fetch address
fetch_done  output  1  one-cycle pulse, fetch_data valid
fetch_data  output  WORD_SIZE  last fetched word (held)
data_req_read  input  1  load request
data_req_write  input  1  store request
data_addr  input  WORD_SIZE  load/store address
data_wdata  input  WORD_SIZE  store data
data_done  output  1  one-cycle pulse, load/store complete
data_rdata  output  WORD_SIZE  last loaded word (held)
sig_fetch  output  1  to memory I/O: fetch access active
sig_read  output  1  to memory I/O: data read active
sig_write  output  1  to memory I/O: data write active
address_fetch_out  output  WORD_SIZE  latched fetch address
address_data_out  output  WORD_SIZE  latched data address
data_write_out  output  WORD_SIZE  latched store data
mem_data_in  input  WORD_SIZE  read data returned from memory I/O
input_ready  input  1  memory completion strobe
busy  output  1  high whenever state != IDLE
timeout_err  output  1  sticky: an access was aborted by timeout

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset values:
  - State IDLE.
  - All sig_*, done and busy outputs 0.
  - fetch_data, data_rdata, latched addresses and write data 0.
  - timeout_err 0, wait counter 0, last_grant = FETCH.
- Reset mid-access: abandons the access on that edge with no done pulse.
- States: IDLE, FETCH, DREAD, DWRITE.
- IDLE:
  - Samples requests at the posedge.
  - Requests are ignored in any cycle where fetch_done or data_done is high (mandatory turnaround cycle).
  - A data request is data_req_read | data_req_write. If both are high, read wins (protocol violation, no error flagged).
  - Only one requester pending: it is granted.
  - Both pending, DATA_PRIORITY=1: data is granted.
  - Both pending, DATA_PRIORITY=0: the requester not equal to last_grant is granted.
  - On grant, latch address (and data_wdata for stores), update last_grant, clear the wait counter, and enter the access state.
- Access states:
  - Exactly one strobe is asserted, registered from state: FETCH→sig_fetch, DREAD→sig_read, DWRITE→sig_write.
  - Strobes first assert the cycle after the request is sampled.
  - Latched address and write data are stable for the whole access; requester changes are ignored.
- Completion:
  - At the posedge where input_ready=1 in an access state, go to IDLE.
  - FETCH: capture mem_data_in into fetch_data. DREAD: capture into data_rdata. DWRITE: capture nothing.
  - Assert the matching done for exactly the next cycle.
  - Minimum latency from request sampled to done high is 2 cycles (input_ready high in the first strobe cycle).
- input_ready while IDLE: ignored.
- Requesters hold req and operands until done. They must deassert or present a new request by the posedge ending the done cycle.
- Timeout (TIMEOUT>0):
  - The wait counter increments every access-state cycle with input_ready=0.
  - When the counter reaches TIMEOUT, the next edge returns to IDLE and pulses the matching done.
  - fetch_data/data_rdata keep their previous values.
  - timeout_err is set and stays 1 until reset.
  - If input_ready coincides with the timeout cycle, normal completion wins and no error is flagged.
- The counter saturates and never wraps.

Test Plan:
- Reset then fetch_req=1, fetch_addr=0x0010; memory returns 0xA5A5 with input_ready on 3rd strobe cycle → sig_fetch high 3 cycles, address_fetch_out=0x0010, fetch_done 1 cycle, fetch_data=0xA5A5, busy drops with done.
- fetch_req and data_req_read both asserted same cycle, DATA_PRIORITY=1, data_addr=0x0020 → DREAD first (sig_read, address_data_out=0x0020), data_done; turnaround cycle; then FETCH granted.
- DATA_PRIORITY=0, both requesters continuously pending for 4 accesses, immediate input_ready → grant order alternates DATA, FETCH, DATA, FETCH (after reset, last_grant=FETCH).
- Store data_addr=0x0030, data_wdata=0x1234, requester changes data_wdata to 0xFFFF after grant → data_write_out stays 0x1234 until data_done; data_rdata unchanged.
- TIMEOUT=4, fetch with input_ready never asserted → abort after 4 waiting cycles, fetch_done pulses, fetch_data holds old value, timeout_err=1 until reset.
- reset asserted during DREAD → next cycle IDLE, sig_read=0, no data_done, timeout_err=0.
